// File: rtl/fetch_pc_if.sv
// Fetch-sequencer bus: start/done handshake, redirect requests and ROM address.
// FETCH_PC_CYCLE_CNT_EN adds the cycle_count signal.
interface fetch_pc_if #(
    parameter int unsigned A     = 10,
    parameter int unsigned OFF_W = 6
);
    logic             start;
    logic             stall;
    logic             jump_en;
    logic [A-1:0]     jump_target;
    logic             branch_en;
    logic [OFF_W-1:0] branch_offset;
    logic             halt;
    logic [A-1:0]     inst_addr;
    logic             running;
    logic             done;
`ifdef FETCH_PC_CYCLE_CNT_EN
    logic [15:0]      cycle_count;
`endif

    modport master (
        output start, stall, jump_en, jump_target, branch_en, branch_offset, halt,
`ifdef FETCH_PC_CYCLE_CNT_EN
        input  cycle_count,
`endif
        input  inst_addr, running, done
    );

    modport slave (
        input  start, stall, jump_en, jump_target, branch_en, branch_offset, halt,
`ifdef FETCH_PC_CYCLE_CNT_EN
        output cycle_count,
`endif
        output inst_addr, running, done
    );
endinterface

// File: rtl/fetch_pc.sv
// Program counter / fetch sequencer driving the combinational instruction ROM.
// Optional FETCH_PC_CYCLE_CNT_EN adds a saturating 16-bit RUN-cycle counter.
module fetch_pc #(
    parameter int unsigned A          = 10,
    parameter int unsigned OFF_W      = 6,
    parameter int unsigned START_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_pc_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALT   = 2'd2,
        UNUSED = 2'd3
    } state_t;

    state_t       state, state_next;
    logic [A-1:0] pc, pc_next;
    logic [A-1:0] offset_ext;
    logic         launch;

    assign offset_ext = {{(A-OFF_W){bus.branch_offset[OFF_W-1]}}, bus.branch_offset};
    assign launch     = (state == IDLE || state == HALT) && bus.start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (bus.halt)  state_next = HALT;
            HALT:    if (bus.start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Next PC: halt and stall both hold; jump beats branch beats sequential.
    always_comb begin
        pc_next = pc;
        if (launch) begin
            pc_next = A'(START_ADDR);
        end else if (state == RUN) begin
            if (bus.halt || bus.stall) pc_next = pc;
            else if (bus.jump_en)      pc_next = bus.jump_target;
            else if (bus.branch_en)    pc_next = pc + offset_ext;
            else                       pc_next = pc + 1'b1;
        end
    end

    assign bus.inst_addr = pc;
    assign bus.running   = (state == RUN);
    assign bus.done      = (state == HALT);

`ifdef FETCH_PC_CYCLE_CNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           cnt <= '0;
        else if (launch)                      cnt <= '0;
        else if (state == RUN && cnt != '1)   cnt <= cnt + 16'd1;
    end

    assign bus.cycle_count = cnt;
`endif
endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed scenarios plus randomized traffic
// compared every cycle against an arithmetic model of the sequencer.
module tb_fetch_pc;
    localparam int unsigned A     = 10;
    localparam int unsigned OFF_W = 6;
    localparam int unsigned START = 0;
    localparam int          MOD   = 1 << A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_pc_if #(.A(A), .OFF_W(OFF_W)) bus ();

    fetch_pc #(.A(A), .OFF_W(OFF_W), .START_ADDR(START)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit cmp_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Model: mode 0=idle, 1=run, 2=halted.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;

    function automatic int sext(input logic [OFF_W-1:0] v);
        return v[OFF_W-1] ? int'(v) - (1 << OFF_W) : int'(v);
    endfunction

    function automatic int wrap(input int v);
        return ((v % MOD) + MOD) % MOD;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_pc   <= 0;
            m_cnt  <= 0;
        end else if (m_mode != 1) begin
            if (bus.start) begin
                m_mode <= 1;
                m_pc   <= START;
                m_cnt  <= 0;
            end
        end else begin
            if (m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (bus.halt)           m_mode <= 2;
            else if (bus.stall)     m_pc <= m_pc;
            else if (bus.jump_en)   m_pc <= int'(bus.jump_target);
            else if (bus.branch_en) m_pc <= wrap(m_pc + sext(bus.branch_offset));
            else                    m_pc <= wrap(m_pc + 1);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_addr", 32'(bus.inst_addr), 32'(m_pc));
            chk("model_running", 32'(bus.running), 32'(m_mode == 1));
            chk("model_done", 32'(bus.done), 32'(m_mode == 2));
`ifdef FETCH_PC_CYCLE_CNT_EN
            chk("model_count", 32'(bus.cycle_count), 32'(m_cnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.start = 0; bus.stall = 0; bus.jump_en = 0; bus.branch_en = 0; bus.halt = 0;
        bus.jump_target = '0; bus.branch_offset = '0;
    endtask

    task automatic chk_state(input string name, input int addr, input bit run, input bit dn);
        chk({name, "_addr"}, 32'(bus.inst_addr), 32'(addr));
        chk({name, "_running"}, 32'(bus.running), 32'(run));
        chk({name, "_done"}, 32'(bus.done), 32'(dn));
    endtask

    task automatic jump_to(input int t);
        bus.jump_en = 1; bus.jump_target = A'(t);
        tick();
        bus.jump_en = 0;
    endtask

    initial begin
        clear_in();
        tick();
        cmp_en = 1'b1;
        chk_state("reset", 0, 0, 0);
        rst_n = 1'b1;
        tick();
        chk_state("idle_hold", 0, 0, 0);

        // Start then free-run 0..5
        bus.start = 1; tick(); bus.start = 0;
        chk_state("start", 0, 1, 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("seq_addr", 32'(bus.inst_addr), 32'(i));
        end
        tick(); tick();
        chk("at7", 32'(bus.inst_addr), 32'd7);

        jump_to(10'h3F0);
        chk("jump", 32'(bus.inst_addr), 32'h3F0);
        bus.branch_en = 1; bus.branch_offset = 6'b111100; tick();
        chk("branch_neg", 32'(bus.inst_addr), 32'h3EC);
        bus.branch_offset = 6'd5; tick(); bus.branch_en = 0;
        chk("branch_pos", 32'(bus.inst_addr), 32'h3F1);

        jump_to(10'h3FF);
        tick();
        chk("wrap_up", 32'(bus.inst_addr), 32'h000);
        tick();
        bus.branch_en = 1; bus.branch_offset = 6'b111110; tick(); bus.branch_en = 0;
        chk("wrap_down", 32'(bus.inst_addr), 32'h3FF);

        // All redirect requests at once: halt must win
        jump_to(20);
        bus.halt = 1; bus.stall = 1; bus.jump_en = 1; bus.jump_target = 10'd5;
        bus.branch_en = 1; bus.branch_offset = 6'd3;
        tick(); clear_in();
        chk_state("prio_halt", 20, 0, 1);
        tick();
        chk_state("halt_hold", 20, 0, 1);
        bus.start = 1; tick(); bus.start = 0;
        chk_state("restart", 0, 1, 0);

        jump_to(9);
        bus.stall = 1; bus.branch_en = 1; bus.branch_offset = 6'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", 32'(bus.inst_addr), 32'd9);
        end
        clear_in(); tick();
        chk("after_stall", 32'(bus.inst_addr), 32'd10);
        bus.start = 1; tick(); bus.start = 0;
        chk_state("start_ignored", 11, 1, 0);

        // 4 run + 2 stall + halt cycle
        bus.halt = 1; tick(); bus.halt = 0;
        bus.start = 1; tick(); bus.start = 0;
        repeat (4) tick();
        bus.stall = 1; repeat (2) tick(); bus.stall = 0;
        bus.halt = 1; tick(); bus.halt = 0;
        chk_state("cnt_halt", 4, 0, 1);
`ifdef FETCH_PC_CYCLE_CNT_EN
        chk("cycle_count", 32'(bus.cycle_count), 32'd7);
        tick();
        chk("cycle_count_hold", 32'(bus.cycle_count), 32'd7);
`endif

        // Asynchronous reset between edges
        bus.start = 1; tick(); bus.start = 0;
        jump_to(10'h55);
        chk("pre_reset", 32'(bus.inst_addr), 32'h55);
        #2 rst_n = 1'b0;
        #1 chk_state("async_reset", 0, 0, 0);
`ifdef FETCH_PC_CYCLE_CNT_EN
        chk("async_reset_count", 32'(bus.cycle_count), 32'd0);
`endif
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            bus.start         = ($urandom_range(0, 3) == 0);
            bus.stall         = ($urandom_range(0, 4) == 0);
            bus.jump_en       = ($urandom_range(0, 5) == 0);
            bus.branch_en     = ($urandom_range(0, 3) == 0);
            bus.halt          = ($urandom_range(0, 23) == 0);
            bus.jump_target   = A'($urandom);
            bus.branch_offset = OFF_W'($urandom);
            tick();
        end
        rst_n = 1'b1;
        clear_in();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
